load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002: clk  in  1  single clock; all state updates on the rising edge.
REQ-003: resetn  in  1  reset, asynchronous, active-low.
REQ-004: req_valid  in  1  CPU load/store request present.
REQ-005: req_ready  out  1  LSU can accept a request (high only in IDLE).
REQ-006: req_we  in  1  1=store, 0=load.
REQ-007: req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008: req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-009: req_addr  in  ADDR_W  byte address.
REQ-010: req_wdata  in  32  store data, right-aligned.
REQ-011: rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012: rsp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-013: rsp_err  out  1  request rejected; qualified by rsp_valid.
REQ-014: mem_addr  out  ADDR_W  word-aligned address to Memory ({addr[ADDR_W-1:2],2'b00}).
REQ-015: mem_rstrb  out  1  one-cycle read strobe to Memory.
REQ-016: mem_wdata  out  32  lane-replicated store data.
REQ-017: mem_wmask  out  4  byte-lane write enables; nonzero for exactly one cycle per store.
REQ-018: mem_rdata  in  32  Memory read data, valid the cycle after mem_rstrb.

Function
REQ-019: FSM states IDLE, ISSUE, LOAD, RESP; handshake completes when req_valid && req_ready at a rising edge (accept edge E0); all request fields are registered at E0.
REQ-020: IDLE -> ISSUE on accept; ISSUE drives mem_addr plus mem_rstrb=1 (load) or mem_wmask (store) for exactly that cycle; mem_rstrb and mem_wmask are 0 in all other states.
REQ-021: Store: ISSUE -> RESP; rsp_valid high in the 2nd cycle after E0.
REQ-022: Load: ISSUE -> LOAD; in LOAD, the aligned/extended mem_rdata is registered into rsp_rdata; LOAD -> RESP; rsp_valid high in the 3rd cycle after E0.
REQ-023: RESP -> IDLE unconditionally; req_ready asserts the cycle after RESP; no request is accepted or dropped while req_ready=0.
REQ-024: Store lanes, off=addr[1:0]: byte wmask=0001<<off, mem_wdata={4{wdata[7:0]}}; half wmask=0011<<off, mem_wdata={2{wdata[15:0]}}; word wmask=1111, mem_wdata=wdata.
REQ-025: Load extraction: byte=mem_rdata[8*off+:8]; half=mem_rdata[8*off+:16]; word=mem_rdata; byte/half extended to 32 bits per req_unsigned; req_unsigned ignored for word.
REQ-026: req_size=11 is always rejected: ISSUE skipped (IDLE -> RESP), no memory strobe, rsp_err=1, rsp_rdata=0.

Reset
REQ-027: resetn low forces IDLE immediately; rsp_valid, rsp_err, rsp_rdata, mem_rstrb, mem_wmask, mem_wdata, mem_addr all 0; req_ready=1 once resetn is released.
REQ-028: Reset mid-operation aborts the request: no rsp_valid is issued for it and a store strobe in flight is withdrawn asynchronously.

Configuration
REQ-029: Macro LSU_MISALIGN_TRAP_EN defined: a half at odd offset or a word at nonzero offset goes IDLE -> RESP with no memory strobe, rsp_err=1, rsp_rdata=0.
REQ-030: Macro LSU_MISALIGN_TRAP_EN undefined: low address bits are truncated (half uses off={addr[1],0}, word uses off=0); misalignment never sets rsp_err.

Structure
REQ-031: Package lsu_pkg holds the req_size encodings (SIZE_B, SIZE_H, SIZE_W) and the FSM state typedef/encoding.
REQ-032: Sub-module lsu_load_align (combinational lane select and sign/zero extension) is instantiated once.

Verification (bench pairs LSU with Memory, 10 ns clock)
REQ-033: Word store 0xDEADBEEF @0x4 -> ISSUE: mem_addr=0x4, wmask=1111; rsp_valid at E0+2. Word load @0x4 -> rsp_rdata=0xDEADBEEF at E0+3.
REQ-034: Byte store wdata=0xAABBCCDD @0xA -> wmask=0100, mem_wdata=0xDDDDDDDD. Signed byte load @0xA -> 0xFFFFFFDD; unsigned -> 0x000000DD.
REQ-035: After REQ-033, half load @0x6 -> signed 0xFFFFDEAD, unsigned 0x0000DEAD; half load @0x4 -> signed 0xFFFFBEEF.
REQ-036: Word load @0x5 -> with macro: rsp_err=1, mem_rstrb never high, rsp_rdata=0; without macro: 0xDEADBEEF, rsp_err=0.
REQ-037: resetn low during the ISSUE cycle of a store to 0x8 -> mem_wmask=0 immediately, no rsp_valid, word at 0x8 unchanged on readback.
REQ-038: req_valid held high over three back-to-back loads plus one size=11 request -> exactly four rsp_valid pulses, in order, last with rsp_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_LOAD  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_t;

  // Effective byte offset once low address bits are truncated to the access size.
  function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  eff_off = off;
      SIZE_H:  eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  store_mask = 4'b0001 << eff_off(size, off);
      SIZE_H:  store_mask = 4'b0011 << eff_off(size, off);
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  store_data = {4{wdata[7:0]}};
      SIZE_H:  store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational lane select and sign/zero extension of memory read data.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = mem_rdata[7:0];
    case (off)
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      2'd3:    byte_c = mem_rdata[31:24];
      default: byte_c = mem_rdata[7:0];
    endcase
    // off[0] is ignored for halves: misaligned halves either trap or truncate upstream
    half_c = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size)
      SIZE_B:  data_c = {{24{~is_unsigned & byte_c[7]}}, byte_c};
      SIZE_H:  data_c = {{16{~is_unsigned & half_c[15]}}, half_c};
      default: data_c = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU load/store unit: one outstanding request, byte/half/word lanes to a word memory.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        reject_c;
  logic [31:0] load_data_c;

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject_c = (req_size == SIZE_X) || misaligned(req_size, req_addr[1:0]);
`else
  assign reject_c = (req_size == SIZE_X);
`endif

  lsu_load_align u_load_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (off_q),
    .mem_rdata   (mem_rdata),
    .data_c      (load_data_c)
  );

  // Request FSM; strobes and response fields default to idle each cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SIZE_B;
      off_q     <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_rstrb <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_rstrb <= 1'b0;
      mem_wmask <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= req_addr[1:0];
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (reject_c) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= ST_ISSUE;
              if (req_we) begin
                mem_wmask <= store_mask(req_size, req_addr[1:0]);
                mem_wdata <= store_data(req_size, req_wdata);
              end else begin
                mem_rstrb <= 1'b1;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data_c;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: load_store_unit paired with a small word-addressed memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata;

  logic              mem_clr;
  logic [31:0]       mem [0:15];

  int passed = 0;
  int total  = 0;

  logic [31:0] i_addr, i_wdata, r_rdata;
  logic [3:0]  i_wmask;
  logic        i_rstrb, any_rstrb, r_err;
  int          r_lat;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Memory: byte-masked writes, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One request: drive at a negedge, then record ISSUE-cycle outputs and the response.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0; r_rdata = '0; r_err = 1'b0; any_rstrb = 1'b0;
    for (int k = 1; k <= 8 && r_lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_addr = mem_addr; i_wmask = mem_wmask; i_wdata = mem_wdata; i_rstrb = mem_rstrb;
      end
      any_rstrb |= mem_rstrb;
      if (rsp_valid) begin r_lat = k; r_rdata = rsp_rdata; r_err = rsp_err; end
    end
  endtask

  initial begin
    logic [31:0] bb_rdata [0:3];
    logic        bb_err [0:3];
    int          n_acc, n_rsp;
    logic        acc;

    resetn = 1'b0; mem_clr = 1'b1; req_valid = 1'b0;
    drive(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rstrb", 32'(mem_rstrb), 32'd0);
    resetn = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    xact(1'b1, SIZE_W, 1'b0, 32'h4, 32'hDEADBEEF);
    chk("sw_addr", i_addr, 32'h4);
    chk("sw_wmask", 32'(i_wmask), 32'hF);
    chk("sw_wdata", i_wdata, 32'hDEADBEEF);
    chk("sw_lat", 32'(r_lat), 32'd2);
    chk("sw_rdata", r_rdata, 32'h0);
    chk("sw_err", 32'(r_err), 32'd0);

    xact(1'b0, SIZE_W, 1'b0, 32'h4, 32'h0);
    chk("lw_rstrb", 32'(i_rstrb), 32'd1);
    chk("lw_lat", 32'(r_lat), 32'd3);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF);

    xact(1'b1, SIZE_B, 1'b0, 32'hA, 32'hAABBCCDD);
    chk("sb_wmask", 32'(i_wmask), 32'h4);
    chk("sb_wdata", i_wdata, 32'hDDDDDDDD);
    chk("sb_addr", i_addr, 32'h8);

    xact(1'b0, SIZE_B, 1'b0, 32'hA, 32'h0);
    chk("lb_signed", r_rdata, 32'hFFFFFFDD);
    xact(1'b0, SIZE_B, 1'b1, 32'hA, 32'h0);
    chk("lb_unsigned", r_rdata, 32'h000000DD);

    xact(1'b0, SIZE_H, 1'b0, 32'h6, 32'h0);
    chk("lh6_signed", r_rdata, 32'hFFFFDEAD);
    xact(1'b0, SIZE_H, 1'b1, 32'h6, 32'h0);
    chk("lh6_unsigned", r_rdata, 32'h0000DEAD);
    xact(1'b0, SIZE_H, 1'b0, 32'h4, 32'h0);
    chk("lh4_signed", r_rdata, 32'hFFFFBEEF);

    xact(1'b1, SIZE_H, 1'b0, 32'hE, 32'hFFFF1234);
    chk("sh_wmask", 32'(i_wmask), 32'hC);
    chk("sh_wdata", i_wdata, 32'h12341234);
    xact(1'b0, SIZE_W, 1'b0, 32'hC, 32'h0);
    chk("lw_c", r_rdata, 32'h12340000);

    xact(1'b0, SIZE_W, 1'b0, 32'h5, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw5_err", 32'(r_err), 32'd1);
    chk("lw5_rstrb", 32'(any_rstrb), 32'd0);
    chk("lw5_rdata", r_rdata, 32'h0);
    chk("lw5_lat", 32'(r_lat), 32'd1);
`else
    chk("lw5_err", 32'(r_err), 32'd0);
    chk("lw5_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw5_lat", 32'(r_lat), 32'd3);
`endif

    xact(1'b1, 2'b11, 1'b0, 32'h8, 32'h55555555);
    chk("ill_err", 32'(r_err), 32'd1);
    chk("ill_lat", 32'(r_lat), 32'd1);
    chk("ill_rdata", r_rdata, 32'h0);
    chk("ill_wmask", 32'(i_wmask), 32'h0);

    // Reset during the ISSUE cycle of a store must withdraw the strobe immediately.
    @(negedge clk);
    drive(1'b1, SIZE_W, 1'b0, 32'h8, 32'h11111111);
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_wmask_pre", 32'(mem_wmask), 32'hF);
    #1 resetn = 1'b0;
    #1 chk("abort_wmask_async", 32'(mem_wmask), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    n_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("abort_no_rsp", 32'(n_rsp), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    xact(1'b0, SIZE_W, 1'b0, 32'h8, 32'h0);
    chk("abort_readback", r_rdata, 32'h00DD0000);

    // Back-to-back requests with req_valid held high throughout.
    @(negedge clk);
    drive(1'b0, SIZE_W, 1'b0, 32'h4, 32'h0);
    req_valid = 1'b1;
    n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 60 && n_rsp < 4; c++) begin
      if (rsp_valid) begin
        bb_rdata[n_rsp] = rsp_rdata; bb_err[n_rsp] = rsp_err; n_rsp++;
      end
      acc = req_valid && req_ready;
      @(posedge clk);
      if (acc) begin
        n_acc++;
        #1;
        case (n_acc)
          1: drive(1'b0, SIZE_W, 1'b0, 32'hC, 32'h0);
          2: drive(1'b0, SIZE_B, 1'b1, 32'hA, 32'h0);
          3: drive(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
          default: req_valid = 1'b0;
        endcase
      end
      @(negedge clk);
    end
    repeat (6) begin
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bb_count", 32'(n_rsp), 32'd4);
    if (n_rsp >= 4) begin
      chk("bb0_rdata", bb_rdata[0], 32'hDEADBEEF);
      chk("bb1_rdata", bb_rdata[1], 32'h12340000);
      chk("bb2_rdata", bb_rdata[2], 32'h000000DD);
      chk("bb3_rdata", bb_rdata[3], 32'h0);
      chk("bb0_err", 32'(bb_err[0]), 32'd0);
      chk("bb2_err", 32'(bb_err[2]), 32'd0);
      chk("bb3_err", 32'(bb_err[3]), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
